// File: rtl/controle_de_senha.sv
// Password lock controller: programmable 3-bit code, limited wrong attempts,
// timed lockout. All outputs are registered from the next-state logic.
module controle_de_senha #(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PROG,
    input  logic       TRY,
    input  logic [2:0] CODE,
    output logic       READY,
    output logic       OPEN,
    output logic       ERRO,
    output logic       BLOQ,
    output logic [1:0] TENT
);

    typedef enum logic [1:0] {
        SEM_SENHA = 2'd0,
        ARMADO    = 2'd1,
        ABERTO    = 2'd2,
        BLOQUEADO = 2'd3
    } state_t;

    localparam logic [1:0] TENT_MAX  = 2'(MAX_TRIES);
    localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_senha;
    logic [1:0] r_tent;
    logic [7:0] r_cnt;
    logic       r_open;
    logic       r_erro;
    logic       r_bloq;
    logic       r_ready;

    state_t     w_state_next;
    logic [2:0] w_senha_next;
    logic [1:0] w_tent_next;
    logic [7:0] w_cnt_next;
    logic       w_erro_next;

    always_comb begin
        w_state_next = r_state;
        w_senha_next = r_senha;
        w_tent_next  = r_tent;
        w_cnt_next   = r_cnt;
        w_erro_next  = 1'b0;
        case (r_state)
            SEM_SENHA: begin
                if (PROG) begin
                    w_senha_next = CODE;
                    w_state_next = ARMADO;
                end
            end
            ARMADO: begin
                if (TRY) begin
                    if (CODE == r_senha) begin
                        w_state_next = ABERTO;
                        w_tent_next  = TENT_MAX;
                    end else begin
                        w_erro_next = 1'b1;
                        // Last remaining attempt consumed: lock and saturate at zero.
                        if (r_tent <= 2'd1) begin
                            w_tent_next  = 2'd0;
                            w_cnt_next   = LOCK_LOAD;
                            w_state_next = BLOQUEADO;
                        end else begin
                            w_tent_next = r_tent - 2'd1;
                        end
                    end
                end
            end
            ABERTO: begin
                if (PROG) begin
                    w_senha_next = CODE;
                    w_state_next = ARMADO;
                end else if (TRY) begin
                    w_state_next = ARMADO;
                end
            end
            BLOQUEADO: begin
                // Counter is loaded with LOCK_CYCLES-1 so BLOQ spans exactly LOCK_CYCLES cycles.
                if (r_cnt == 8'd0) begin
                    w_state_next = ARMADO;
                    w_tent_next  = TENT_MAX;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: w_state_next = SEM_SENHA;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= SEM_SENHA;
            r_senha <= 3'b000;
            r_tent  <= TENT_MAX;
            r_cnt   <= 8'd0;
            r_open  <= 1'b0;
            r_erro  <= 1'b0;
            r_bloq  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_senha <= w_senha_next;
            r_tent  <= w_tent_next;
            r_cnt   <= w_cnt_next;
            r_open  <= (w_state_next == ABERTO);
            r_erro  <= w_erro_next;
            r_bloq  <= (w_state_next == BLOQUEADO);
            r_ready <= (w_state_next != BLOQUEADO);
        end
    end

    assign READY = r_ready;
    assign OPEN  = r_open;
    assign ERRO  = r_erro;
    assign BLOQ  = r_bloq;
    assign TENT  = r_tent;

endmodule

// File: tb/tb_controle_de_senha.sv
// Directed bench for controle_de_senha: programming, opening, wrong attempts,
// lockout timing, async reset abort.
module tb_controle_de_senha;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PROG;
    logic       TRY;
    logic [2:0] CODE;
    logic       READY;
    logic       OPEN;
    logic       ERRO;
    logic       BLOQ;
    logic [1:0] TENT;

    int n_tests = 0;
    int n_fail  = 0;

    controle_de_senha #(.MAX_TRIES(3), .LOCK_CYCLES(8)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .PROG (PROG),
        .TRY  (TRY),
        .CODE (CODE),
        .READY(READY),
        .OPEN (OPEN),
        .ERRO (ERRO),
        .BLOQ (BLOQ),
        .TENT (TENT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic open_e, input logic erro_e,
                           input logic bloq_e, input logic ready_e, input logic [1:0] tent_e);
        chk({tag, ".OPEN"},  {1'b0, OPEN},  {1'b0, open_e});
        chk({tag, ".ERRO"},  {1'b0, ERRO},  {1'b0, erro_e});
        chk({tag, ".BLOQ"},  {1'b0, BLOQ},  {1'b0, bloq_e});
        chk({tag, ".READY"}, {1'b0, READY}, {1'b0, ready_e});
        chk({tag, ".TENT"},  TENT,          tent_e);
        $display("[TB] %s: PROG=%b TRY=%b CODE=%b -> OPEN=%b ERRO=%b BLOQ=%b READY=%b TENT=%0d",
                 tag, PROG, TRY, CODE, OPEN, ERRO, BLOQ, READY, TENT);
    endtask

    // Apply inputs for one edge, then sample 1 time unit after it.
    task automatic step(input logic p, input logic t, input logic [2:0] c);
        PROG = p;
        TRY  = t;
        CODE = c;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; PROG = 1'b0; TRY = 1'b0; CODE = 3'b000;
        #3;
        chk_all("reset", 0, 0, 0, 1, 2'd3);
        @(negedge CLK);
        RST = 1'b0;

        // Unprogrammed: TRY ignored
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 3'b000);
            chk_all($sformatf("nopass_try%0d", i), 0, 0, 0, 1, 2'd3);
        end

        step(1, 0, 3'b101); chk_all("prog101", 0, 0, 0, 1, 2'd3);
        step(0, 1, 3'b101); chk_all("open101", 1, 0, 0, 1, 2'd3);
        step(0, 0, 3'b000); chk_all("hold_open", 1, 0, 0, 1, 2'd3);
        step(0, 1, 3'b000); chk_all("close", 0, 0, 0, 1, 2'd3);

        step(0, 1, 3'b100); chk_all("wrong100", 0, 1, 0, 1, 2'd2);
        step(0, 0, 3'b000); chk_all("idle1", 0, 0, 0, 1, 2'd2);
        step(0, 1, 3'b001); chk_all("wrong001", 0, 1, 0, 1, 2'd1);
        step(0, 0, 3'b000); chk_all("idle2", 0, 0, 0, 1, 2'd1);

        // PROG in ARMADO must not change the password
        step(1, 0, 3'b111); chk_all("prog_armado", 0, 0, 0, 1, 2'd1);
        step(0, 1, 3'b101); chk_all("reopen101", 1, 0, 0, 1, 2'd3);
        step(0, 1, 3'b111); chk_all("close2", 0, 0, 0, 1, 2'd3);

        // Held TRY with wrong code: three attempts, then lockout
        step(0, 1, 3'b000); chk_all("lock_w1", 0, 1, 0, 1, 2'd2);
        step(0, 1, 3'b000); chk_all("lock_w2", 0, 1, 0, 1, 2'd1);
        step(0, 1, 3'b000); chk_all("lock_w3", 0, 1, 1, 0, 2'd0);
        for (int i = 2; i <= 8; i++) begin
            step(i == 4, 1, (i == 4) ? 3'b010 : 3'b101);
            chk_all($sformatf("lock_cyc%0d", i), 0, 0, 1, 0, 2'd0);
        end
        step(0, 1, 3'b101); chk_all("lock_exit", 0, 0, 0, 1, 2'd3);
        step(0, 1, 3'b101); chk_all("open_after_lock", 1, 0, 0, 1, 2'd3);

        // PROG beats TRY in ABERTO
        step(1, 1, 3'b011); chk_all("prog_try_open", 0, 0, 0, 1, 2'd3);
        step(0, 1, 3'b101); chk_all("old_code_wrong", 0, 1, 0, 1, 2'd2);
        step(0, 1, 3'b011); chk_all("new_code_open", 1, 0, 0, 1, 2'd3);
        step(0, 1, 3'b000); chk_all("close3", 0, 0, 0, 1, 2'd3);

        // Lock again and abort with RST in cycle 4 of 8
        step(0, 1, 3'b000); chk_all("l2_w1", 0, 1, 0, 1, 2'd2);
        step(0, 1, 3'b000); chk_all("l2_w2", 0, 1, 0, 1, 2'd1);
        step(0, 1, 3'b000); chk_all("l2_w3", 0, 1, 1, 0, 2'd0);
        for (int i = 2; i <= 4; i++) begin
            step(0, 0, 3'b000);
            chk_all($sformatf("l2_cyc%0d", i), 0, 0, 1, 0, 2'd0);
        end
        #1;
        RST = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 1, 2'd3);
        @(negedge CLK);
        RST = 1'b0;
        step(0, 1, 3'b000); chk_all("post_rst_try000", 0, 0, 0, 1, 2'd3);
        step(1, 0, 3'b000); chk_all("prog000", 0, 0, 0, 1, 2'd3);
        step(0, 1, 3'b000); chk_all("open000", 1, 0, 0, 1, 2'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_de_senha.md
CONTROLE_DE_SENHA -- requirements
Module: controle_de_senha

Interface
REQ-001 Parameter MAX_TRIES, default 3, meaning: consecutive wrong attempts that trigger lockout (legal range 1..3).
REQ-002 Parameter LOCK_CYCLES, default 8, meaning: lockout duration in CLK cycles (legal range 1..255).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 PROG  input  1  request to store CODE as the new password; sampled on the rising edge of CLK.
REQ-006 TRY  input  1  attempt strobe; CODE is compared when TRY=1 on the rising edge of CLK.
REQ-007 CODE  input  3  candidate code or new password.
REQ-008 READY  output  1  block accepts PROG/TRY this cycle.
REQ-009 OPEN  output  1  level; lock open.
REQ-010 ERRO  output  1  one-cycle pulse; wrong attempt registered.
REQ-011 BLOQ  output  1  level; lockout active.
REQ-012 TENT  output  2  remaining wrong attempts before lockout.

Function
REQ-013 FSM states SHALL be: SEM_SENHA (no password), ARMADO, ABERTO, BLOQUEADO.
REQ-014 All outputs SHALL be registered; the response to a sampled PROG/TRY SHALL appear in the cycle after the sampling edge.
REQ-015 SEM_SENHA: PROG=1 -> store CODE, go to ARMADO. TRY is ignored.
REQ-016 ARMADO: TRY=1 with CODE equal bit-for-bit to the stored password -> ABERTO, TENT reloads to MAX_TRIES.
REQ-017 ARMADO: TRY=1 with a mismatching CODE -> ERRO pulses for 1 cycle and TENT decrements by 1.
REQ-018 ARMADO: when TENT would reach 0 -> ERRO pulses, BLOQ=1 in the same cycle, go to BLOQUEADO, and TENT reads 0.
REQ-019 ARMADO: PROG is ignored, with or without TRY.
REQ-020 ABERTO: OPEN=1 for as long as the state is held.
REQ-021 ABERTO: PROG=1 -> store CODE, go to ARMADO, OPEN=0.
REQ-022 ABERTO: TRY=1 without PROG -> close, go to ARMADO; CODE is not compared.
REQ-023 ABERTO: simultaneous PROG and TRY -> PROG wins.
REQ-024 BLOQUEADO: BLOQ=1 for exactly LOCK_CYCLES cycles, counted by an internal down-counter.
REQ-025 BLOQUEADO: PROG and TRY are ignored; no counter, password or ERRO change.
REQ-026 BLOQUEADO: on counter expiry -> ARMADO, BLOQ=0, TENT=MAX_TRIES; the stored password is retained.
REQ-027 READY SHALL be 1 in SEM_SENHA, ARMADO and ABERTO, and 0 in BLOQUEADO.
REQ-028 TENT SHALL saturate: no decrement below 0 and no wrap-around.
REQ-029 TRY and PROG SHALL be level-sampled every cycle; holding TRY=1 for N cycles with a wrong code SHALL count as N attempts.

Reset
REQ-030 RST=1 SHALL immediately, without waiting for CLK, force: state SEM_SENHA, stored password 000, OPEN=0, ERRO=0, BLOQ=0, READY=1, TENT=MAX_TRIES, lock counter 0.
REQ-031 RST asserted mid-lockout or mid-ERRO pulse SHALL abort it; the first edge after RST release is processed normally.

Verification
REQ-032 Reset, PROG=1 CODE=101, then TRY=1 CODE=101 -> ARMADO, then OPEN=1 one cycle after TRY, TENT=3.
REQ-033 Stored 101, TRY with 100 then 001 -> two ERRO pulses, TENT 3->2->1, OPEN stays 0, BLOQ stays 0.
REQ-034 Stored 101, three wrong TRYs -> third response has ERRO=1, BLOQ=1, TENT=0, READY=0. BLOQ then stays 1 for exactly 8 cycles while TRY=1 CODE=101 is applied throughout with no effect. After that BLOQ=0 and TENT=3.
REQ-035 In ABERTO, PROG=1 and TRY=1 with CODE=011 -> ARMADO, OPEN=0. A later TRY with 101 gives ERRO; a later TRY with 011 gives OPEN=1.
REQ-036 Mid-lockout (cycle 4 of 8) RST pulse -> SEM_SENHA, BLOQ=0, TENT=3, password 000; then TRY=1 CODE=000 -> no OPEN, because no password is programmed.
REQ-037 SEM_SENHA, TRY=1 CODE=000 for 5 cycles -> no OPEN, no ERRO, TENT=3.
